keypad_scan: RTL and testbench

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/lock_pkg.sv | 33 +++
 rtl/key_fifo.sv | 62 ++++++
 rtl/keypad_scan.sv | 108 ++++++++++
 tb/tb_keypad_scan.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lock_pkg
// Brief    : Shared FSM state type, default sizing and encoder helpers for keypad_scan.
// Revision : 1.0
// ============================================================================
package lock_pkg;

    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_RELEASE = 2'd2
    } scan_state_t;

    localparam int c_default_scan_div   = 50_000;
    localparam int c_default_fifo_depth = 4;

    // Position of the set bit; only meaningful when the vector is one-hot.
    function automatic logic [1:0] onehot_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_fifo.sv
`default_nettype none
// ============================================================================
// Module   : key_fifo
// Brief    : Small synchronous FIFO for key codes; push while full succeeds only with a pop.
// Revision : 1.0
// ============================================================================
module key_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_pop;
    logic               w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (c_ptr_w + 1)'(DEPTH));
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan
// Brief    : 4x4 keypad column scanner with press capture and buffered key codes.
// Revision : 1.0
// ============================================================================
module keypad_scan
    import lock_pkg::*;
#(
    parameter int SCAN_DIV   = c_default_scan_div,
    parameter int FIFO_DEPTH = c_default_fifo_depth
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] Row,
    input  logic       S_Row,
    output logic [3:0] Col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       overflow
);

    localparam int                 c_cnt_w    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(SCAN_DIV - 1);

    scan_state_t        r_state;
    scan_state_t        w_state_nxt;
    logic [3:0]         r_col;
    logic [3:0]         w_col_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               r_overflow;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [3:0]         w_code;

    assign w_code    = {onehot_index(Row), onehot_index(r_col)};
    assign w_pop     = ~w_empty & key_ready;
    assign Col       = r_col;
    assign key_valid = ~w_empty;
    assign overflow  = r_overflow;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_SCAN;
            r_col      <= 4'b0001;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_col      <= w_col_nxt;
            r_cnt      <= w_cnt_nxt;
            r_overflow <= w_push & w_full & ~w_pop;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        case (r_state)
            ST_SCAN: begin
                // A press freezes column and counter so the capture sees the same column.
                if (S_Row) begin
                    w_state_nxt = ST_CAPTURE;
                end else if (r_cnt == c_cnt_last) begin
                    w_cnt_nxt = '0;
                    w_col_nxt = {r_col[2:0], r_col[3]};
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            ST_CAPTURE: begin
                w_push      = is_onehot(Row);
                w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (Row == 4'b0000) begin
                    w_state_nxt = ST_SCAN;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_SCAN;
            end
        endcase
    end

    key_fifo #(
        .WIDTH (4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .din   (w_code),
        .pop   (w_pop),
        .dout  (key_code),
        .empty (w_empty),
        .full  (w_full)
    );

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan
// Brief    : Directed scoreboard bench for keypad_scan (SCAN_DIV=4, FIFO_DEPTH=4).
// Revision : 1.0
// ============================================================================
module tb_keypad_scan;
    import lock_pkg::*;

    localparam int SCAN_DIV   = 4;
    localparam int FIFO_DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] Row;
    logic       S_Row;
    logic [3:0] Col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       overflow;

    int         errors     = 0;
    int         checks     = 0;
    int         ovf_pulses = 0;
    logic [3:0] exp_q [$];
    logic [3:0] mon_exp;

    keypad_scan #(
        .SCAN_DIV   (SCAN_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .Row       (Row),
        .S_Row     (S_Row),
        .Col       (Col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted transfer is compared against the scoreboard head.
    always @(negedge clock) begin
        if (!reset && overflow) ovf_pulses++;
        if (!reset && key_valid && key_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got code %0d expected no data", key_code);
            end else begin
                mon_exp = exp_q.pop_front();
                check("pop_code", {4'b0, key_code}, {4'b0, mon_exp});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_col(input logic [3:0] target);
        int n = 0;
        while (Col !== target && n < 64) begin
            tick();
            n++;
        end
        if (Col !== target) check("wait_col_timeout", {4'b0, Col}, {4'b0, target});
    endtask

    task automatic press(input logic [3:0] col, input logic [3:0] row, input logic [3:0] code,
                         input logic store, input logic ovf, input logic cap_ready);
        wait_col(col);
        if (store) exp_q.push_back(code);
        Row   = row;
        S_Row = 1'b1;
        tick();
        S_Row = 1'b0;
        check("state_capture", {6'b0, dut.r_state}, {6'b0, ST_CAPTURE});
        check("col_frozen_capture", {4'b0, Col}, {4'b0, col});
        if (cap_ready) key_ready = 1'b1;
        tick();
        if (cap_ready) key_ready = 1'b0;
        check("state_release", {6'b0, dut.r_state}, {6'b0, ST_RELEASE});
        check("overflow_after_capture", {7'b0, overflow}, {7'b0, ovf});
    endtask

    task automatic release_key(input logic [3:0] col);
        tick();
        check("col_hold_release", {4'b0, Col}, {4'b0, col});
        Row = 4'b0000;
        tick();
        check("state_scan_after_release", {6'b0, dut.r_state}, {6'b0, ST_SCAN});
        check("col_unchanged_after_release", {4'b0, Col}, {4'b0, col});
    endtask

    task automatic drain();
        int n = 0;
        key_ready = 1'b1;
        while (key_valid && n < 20) begin
            tick();
            n++;
        end
        key_ready = 1'b0;
        check("drain_empty", {7'b0, key_valid}, 8'd0);
        check("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    endtask

    initial begin
        reset     = 1'b1;
        Row       = 4'b0000;
        S_Row     = 1'b0;
        key_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        check("reset_state", {6'b0, dut.r_state}, {6'b0, ST_SCAN});
        check("reset_col", {4'b0, Col}, 8'd1);
        check("reset_key_valid", {7'b0, key_valid}, 8'd0);
        check("reset_key_code", {4'b0, key_code}, 8'd0);
        check("reset_overflow", {7'b0, overflow}, 8'd0);

        // Idle rotation: each column held for SCAN_DIV cycles.
        for (int i = 0; i < 20; i++) begin
            check("idle_col", {4'b0, Col}, 8'(1 << ((i / SCAN_DIV) % 4)));
            if (i < 19) tick();
        end
        check("idle_key_valid", {7'b0, key_valid}, 8'd0);

        // Single press: row 1, column 2 -> code 6.
        press(4'b0100, 4'b0010, 4'd6, 1'b1, 1'b0, 1'b0);
        check("press_key_valid", {7'b0, key_valid}, 8'd1);
        check("press_key_code", {4'b0, key_code}, 8'd6);
        release_key(4'b0100);
        drain();

        // Two rows at once: nothing stored.
        press(4'b1000, 4'b0110, 4'd0, 1'b0, 1'b0, 1'b0);
        check("multi_row_no_push", {7'b0, key_valid}, 8'd0);
        release_key(4'b1000);

        // Five presses without a consumer: fifth is dropped.
        press(4'b0001, 4'b0001, 4'd0,  1'b1, 1'b0, 1'b0); release_key(4'b0001);
        press(4'b0010, 4'b0001, 4'd1,  1'b1, 1'b0, 1'b0); release_key(4'b0010);
        press(4'b0100, 4'b0100, 4'd10, 1'b1, 1'b0, 1'b0); release_key(4'b0100);
        press(4'b1000, 4'b1000, 4'd15, 1'b1, 1'b0, 1'b0); release_key(4'b1000);
        check("held_code_stable", {4'b0, key_code}, 8'd0);
        press(4'b0001, 4'b0010, 4'd4,  1'b0, 1'b1, 1'b0); release_key(4'b0001);
        check("overflow_single_pulse", {7'b0, overflow}, 8'd0);
        drain();

        // Full FIFO with push and pop on the same edge.
        press(4'b0010, 4'b0010, 4'd5,  1'b1, 1'b0, 1'b0); release_key(4'b0010);
        press(4'b0100, 4'b0001, 4'd2,  1'b1, 1'b0, 1'b0); release_key(4'b0100);
        press(4'b1000, 4'b0010, 4'd7,  1'b1, 1'b0, 1'b0); release_key(4'b1000);
        press(4'b0001, 4'b1000, 4'd12, 1'b1, 1'b0, 1'b0); release_key(4'b0001);
        press(4'b0010, 4'b0100, 4'd9,  1'b1, 1'b0, 1'b1);
        check("occupancy_full", {5'b0, dut.u_fifo.r_count}, 8'd4);
        release_key(4'b0010);
        drain();

        // Reset while in RELEASE with two codes queued.
        press(4'b0100, 4'b0001, 4'd8,  1'b1, 1'b0, 1'b0); release_key(4'b0100);
        press(4'b1000, 4'b0100, 4'd11, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        check("mid_reset_state", {6'b0, dut.r_state}, {6'b0, ST_SCAN});
        check("mid_reset_col", {4'b0, Col}, 8'd1);
        check("mid_reset_key_valid", {7'b0, key_valid}, 8'd0);
        check("mid_reset_key_code", {4'b0, key_code}, 8'd0);
        exp_q.delete();
        reset = 1'b0;
        Row   = 4'b0000;
        tick();
        check("post_reset_key_valid", {7'b0, key_valid}, 8'd0);

        check("overflow_pulse_count", 8'(ovf_pulses), 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
